// File: rtl/trig_pkg.sv
// Shared trig constants for the CORDIC units: atan table (12 fraction bits),
// 4.8 angle constants, the CORDIC gain correction K^-1 (0.12), and the atan2 FSM states.
package trig_pkg;

   localparam int LUT_FRAC  = 12;
   localparam int LUT_DEPTH = 16;

   // round(atan(2^-i) * 2^12)
   localparam logic [15:0] ATAN_LUT [LUT_DEPTH] = '{
      16'd3217, 16'd1899, 16'd1003, 16'd509, 16'd256, 16'd128, 16'd64, 16'd32,
      16'd16,   16'd8,    16'd4,    16'd2,   16'd1,   16'd0,   16'd0,  16'd0
   };

   localparam logic [11:0] PI      = 12'h324;
   localparam logic [11:0] TWO_PI  = 12'h648;
   localparam logic [11:0] HALF_PI = 12'h192;
   localparam logic [11:0] K_INV   = 12'h9b7;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PRE  = 3'd1,
      ST_ITER = 3'd2,
      ST_POST = 3'd3,
      ST_DONE = 3'd4
   } atan_state_e;

endpackage

// File: rtl/cal_atan2_cordic_vec_stage.sv
// One CORDIC vectoring micro-rotation: steers y toward zero and accumulates the
// rotation angle in z. The shift amount selects the iteration.
module cordic_vec_stage #(
   parameter int W  = 16,
   parameter int ZW = 18,
   parameter int SW = 4
) (
   input  logic signed [W-1:0]  x_i,
   input  logic signed [W-1:0]  y_i,
   input  logic signed [ZW-1:0] z_i,
   input  logic        [SW-1:0] shift_i,
   input  logic signed [ZW-1:0] atan_i,
   output logic signed [W-1:0]  x_o,
   output logic signed [W-1:0]  y_o,
   output logic signed [ZW-1:0] z_o
);

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;

   assign x_sh = x_i >>> shift_i;
   assign y_sh = y_i >>> shift_i;

   always_comb begin
      if (y_i[W-1]) begin
         x_o = x_i - y_sh;
         y_o = y_i + x_sh;
         z_o = z_i - atan_i;
      end else begin
         x_o = x_i + y_sh;
         y_o = y_i - x_sh;
         z_o = z_i + atan_i;
      end
   end

endmodule

// File: rtl/cal_atan2.sv
// Iterative CORDIC atan2/magnitude unit, one request in flight, result held until taken.
// Defining CAL_ATAN2_MAG_EN adds the K^-1 scaled magnitude output; otherwise mag is 0.
module cal_atan2
   import trig_pkg::*;
#(
   parameter int WII  = 4,
   parameter int WIF  = 8,
   parameter int WOI  = 2,
   parameter int WOF  = 12,
   parameter int ITER = 12
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WOI+WOF-1:0]   x,
   input  logic [WOI+WOF-1:0]   y,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WII+WIF-1:0]   angle,
   output logic [WOI+WOF:0]     mag
);

   // Valid/ready: a transfer happens on a rising edge where valid and ready are
   // both high; the producer holds valid and data stable until that edge.

   localparam int XW = WOI + WOF + 2;
   localparam int AW = WII + WIF;
   localparam int MW = WOI + WOF + 1;
   localparam int ZW = AW + 6;
   localparam int RS = LUT_FRAC - WIF;
   localparam int CW = $clog2(LUT_DEPTH);

   // Angle constants are 4.8, so WIF is expected to stay 8.
   localparam logic signed [ZW-1:0] PI_Z     = ZW'(PI) << RS;
   localparam logic signed [ZW-1:0] TWO_PI_A = ZW'(TWO_PI);
   localparam logic signed [ZW-1:0] RND_Z    = ZW'(1) << (RS - 1);

   atan_state_e          state_q, state_d;
   logic signed [XW-1:0] x_q, x_d, y_q, y_d, x_nxt, y_nxt;
   logic signed [ZW-1:0] z_q, z_d, z_nxt, atan_cur;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 fold_q, fold_d, zero_q, zero_d;
   logic [AW-1:0]        angle_q, angle_d, angle_post;
   logic [MW-1:0]        mag_q, mag_d, mag_post;
   logic signed [ZW-1:0] sum_z, rnd_z, ang_w;

   assign atan_cur = ZW'(ATAN_LUT[cnt_q]);

   cordic_vec_stage #(.W(XW), .ZW(ZW), .SW(CW)) u_stage (
      .x_i     (x_q),
      .y_i     (y_q),
      .z_i     (z_q),
      .shift_i (cnt_q),
      .atan_i  (atan_cur),
      .x_o     (x_nxt),
      .y_o     (y_nxt),
      .z_o     (z_nxt)
   );

   // Undo the half-plane fold, round to output precision, wrap into [0, 2pi).
   always_comb begin
      sum_z = fold_q ? (z_q + PI_Z) : z_q;
      rnd_z = (sum_z + RND_Z) >>> RS;
      ang_w = rnd_z[ZW-1] ? (rnd_z + TWO_PI_A) : rnd_z;
      angle_post = (zero_q || (ang_w >= TWO_PI_A)) ? '0 : AW'(ang_w);
   end

`ifdef CAL_ATAN2_MAG_EN
   localparam int PW = XW + 13;
   logic signed [PW-1:0] prod;
   assign prod     = PW'(x_q) * PW'($signed({1'b0, K_INV}));
   assign mag_post = MW'((prod + PW'(2048)) >>> 12);
`else
   assign mag_post = '0;
`endif

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      cnt_d   = cnt_q;
      fold_d  = fold_q;
      zero_d  = zero_q;
      angle_d = angle_q;
      mag_d   = mag_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               x_d     = XW'($signed(x));
               y_d     = XW'($signed(y));
               z_d     = '0;
               cnt_d   = '0;
               state_d = ST_PRE;
            end
         end
         ST_PRE: begin
            zero_d = (x_q == '0) && (y_q == '0);
            fold_d = x_q[XW-1];
            if (x_q[XW-1]) begin
               x_d = -x_q;
               y_d = -y_q;
            end
            state_d = ST_ITER;
         end
         ST_ITER: begin
            x_d   = x_nxt;
            y_d   = y_nxt;
            z_d   = z_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) state_d = ST_POST;
         end
         ST_POST: begin
            angle_d = angle_post;
            mag_d   = mag_post;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         cnt_q   <= '0;
         fold_q  <= 1'b0;
         zero_q  <= 1'b0;
         angle_q <= '0;
         mag_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         cnt_q   <= cnt_d;
         fold_q  <= fold_d;
         zero_q  <= zero_d;
         angle_q <= angle_d;
         mag_q   <= mag_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign angle     = angle_q;
   assign mag       = mag_q;

endmodule

// File: tb/tb_cal_atan2.sv
// Self-checking bench for cal_atan2: directed vector table, handshake/reset sequences,
// and random vectors against a real-arithmetic atan2/hypot reference.
module tb_cal_atan2;

   localparam int  ITER   = 12;
   localparam int  TWO_PI = 1608;
   localparam real PI_R   = 3.14159265358979;

   logic        Clk, Reset_n, in_valid, in_ready, out_valid, out_ready;
   logic [13:0] x, y;
   logic [11:0] angle;
   logic [14:0] mag;

   int n_tests = 0;
   int n_fail  = 0;
   logic [11:0] exp_q[$];

   typedef struct {
      logic [13:0] vx;
      logic [13:0] vy;
      logic [11:0] ang;
      int          atol;
      int          mg;
   } vec_t;

   vec_t vecs[10];

   cal_atan2 #(.WII(4), .WIF(8), .WOI(2), .WOF(12), .ITER(ITER)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .angle     (angle),
      .mag       (mag)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1);
   end

   function automatic int ref_angle(input int xi, input int yi);
      real a;
      int  r;
      a = $atan2(real'(yi), real'(xi));
      if (a < 0.0) a = a + 2.0 * PI_R;
      r = int'($floor(a * 256.0 + 0.5));
      return r % TWO_PI;
   endfunction

   function automatic int ref_mag(input int xi, input int yi);
      return int'($floor($sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi)) + 0.5));
   endfunction

   task automatic check_eq(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic check_tol(input string nm, input int act, input int exp, input int tol);
      int d;
      n_tests++;
      d = (act > exp) ? act - exp : exp - act;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, exp, tol);
      end
   endtask

   // Angle distance measured around the circle so 1607 and 0 are neighbours.
   task automatic check_ang(input string nm, input int act, input int exp, input int tol);
      int d;
      n_tests++;
      d = (act > exp) ? act - exp : exp - act;
      if (TWO_PI - d < d) d = TWO_PI - d;
      if (act >= TWO_PI) d = 9999;
      if (d > tol) begin
         n_fail++;
         $display("FAIL %s: angle got %0d expected %0d +/-%0d", nm, act, exp, tol);
      end
   endtask

   task automatic check_mag(input string nm, input int act, input int exp_true);
`ifdef CAL_ATAN2_MAG_EN
      check_tol(nm, act, exp_true, 3);
`else
      check_eq(nm, act, (exp_true < 0) ? exp_true : 0);
`endif
   endtask

   task automatic do_reset();
      Reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x = '0;
      y = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   // Called at a negedge; returns the result and the edge count from handshake to out_valid.
   task automatic do_req(input logic [13:0] xi, input logic [13:0] yi,
                         output logic [11:0] ang, output logic [14:0] mg, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge Clk);
         guard++;
      end
      in_valid = 1'b1;
      x = xi;
      y = yi;
      @(posedge Clk);
      lat = 1;
      @(negedge Clk);
      in_valid = 1'b0;
      x = 14'($urandom);
      y = 14'($urandom);
      while (!out_valid && lat < 64) begin
         @(posedge Clk);
         @(negedge Clk);
         lat++;
      end
      if (!out_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL req_timeout: out_valid=0 after %0d cycles, required 1", lat);
      end
      ang = angle;
      mg  = mag;
      out_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [11:0] ang, ang0;
      logic [14:0] mg, mg0;
      int lat, bad_ready, bad_stable, xr, yr, e;

      do_reset();
      check_eq("reset_in_ready", int'(in_ready), 1);
      check_eq("reset_out_valid", int'(out_valid), 0);
      check_eq("reset_angle", int'(angle), 0);
      check_eq("reset_mag", int'(mag), 0);

      vecs[0] = '{14'h1000, 14'h0000, 12'h000, 0, 4096};
      vecs[1] = '{14'h0000, 14'h1000, 12'h192, 1, 4096};
      vecs[2] = '{14'h3000, 14'h0000, 12'h324, 1, 4096};
      vecs[3] = '{14'h0000, 14'h3000, 12'h4b6, 1, 4096};
      vecs[4] = '{14'h0b50, 14'h34b0, 12'h57f, 1, 4096};
      vecs[5] = '{14'h1000, 14'h3fff, 12'h000, 0, 4096};
      vecs[6] = '{14'h0000, 14'h0000, 12'h000, 0, 0};
      vecs[7] = '{14'h2000, 14'h0000, 12'h324, 1, 8192};
      vecs[8] = '{14'h0000, 14'h2000, 12'h4b6, 1, 8192};
      vecs[9] = '{14'h2000, 14'h2000, 12'h3ed, 1, 11585};

      for (int i = 0; i < 10; i++) begin
         do_req(vecs[i].vx, vecs[i].vy, ang, mg, lat);
         check_ang($sformatf("vec%0d_angle", i), int'(ang), int'(vecs[i].ang), vecs[i].atol);
         check_mag($sformatf("vec%0d_mag", i), int'(mg), vecs[i].mg);
         check_eq($sformatf("vec%0d_latency", i), lat, ITER + 3);
      end

      // Stall: result must appear at ITER+3 and hold while out_ready stays low,
      // with a competing in_valid that must not be taken.
      bad_ready  = 0;
      bad_stable = 0;
      in_valid = 1'b1;
      x = 14'h0000;
      y = 14'h1000;
      @(posedge Clk);
      lat = 1;
      @(negedge Clk);
      x = 14'h1000;
      y = 14'h0000;
      while (!out_valid && lat < 64) begin
         if (in_ready) bad_ready++;
         @(posedge Clk);
         @(negedge Clk);
         lat++;
      end
      check_eq("stall_latency", lat, ITER + 3);
      ang0 = angle;
      mg0  = mag;
      check_ang("stall_angle", int'(ang0), 12'h192, 1);
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (in_ready) bad_ready++;
         if (!out_valid || angle != ang0 || mag != mg0) bad_stable++;
      end
      check_eq("stall_in_ready_low", bad_ready, 0);
      check_eq("stall_result_stable", bad_stable, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      out_ready = 1'b0;
      check_eq("release_in_ready", int'(in_ready), 1);
      check_eq("release_out_valid", int'(out_valid), 0);

      // Reset in the middle of the iterations; held angle from the previous result must clear.
      in_valid = 1'b1;
      x = 14'h3000;
      y = 14'h0000;
      @(posedge Clk);
      @(negedge Clk);
      in_valid = 1'b0;
      repeat (6) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      check_eq("midreset_out_valid", int'(out_valid), 0);
      check_eq("midreset_in_ready", int'(in_ready), 1);
      check_eq("midreset_angle", int'(angle), 0);
      check_eq("midreset_mag", int'(mag), 0);
      bad_stable = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge Clk);
         @(negedge Clk);
         if (out_valid || !in_ready) bad_stable++;
      end
      check_eq("midreset_stays_idle", bad_stable, 0);
      do_req(14'h0b50, 14'h34b0, ang, mg, lat);
      check_ang("after_midreset_angle", int'(ang), 12'h57f, 1);
      check_eq("after_midreset_latency", lat, ITER + 3);

      // Reset while a finished result is stalled.
      in_valid = 1'b1;
      x = 14'h3000;
      y = 14'h0000;
      @(posedge Clk);
      @(negedge Clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 64) begin
         @(posedge Clk);
         @(negedge Clk);
         lat++;
      end
      check_ang("done_stall_angle", int'(angle), 12'h324, 1);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      Reset_n = 1'b1;
      check_eq("donereset_out_valid", int'(out_valid), 0);
      check_eq("donereset_in_ready", int'(in_ready), 1);
      check_eq("donereset_angle", int'(angle), 0);

      do_req(14'h1000, 14'h0000, ang, mg, lat);
      check_ang("after_donereset_angle", int'(ang), 12'h000, 0);

      // Random vectors away from the origin, where quantisation dominates the angle.
      for (int n = 0; n < 1000; n++) begin
         do begin
            xr = int'($urandom_range(16383)) - 8192;
            yr = int'($urandom_range(16383)) - 8192;
         end while (xr * xr + yr * yr < 1024 * 1024);
         exp_q.push_back(12'(ref_angle(xr, yr)));
         do_req(14'(xr), 14'(yr), ang, mg, lat);
         e = int'(exp_q.pop_front());
         check_ang($sformatf("rand%0d_angle(x=%0d,y=%0d)", n, xr, yr), int'(ang), e, 2);
         check_mag($sformatf("rand%0d_mag", n), int'(mg), ref_mag(xr, yr));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
